// File: rtl/booth_pkg.sv
// Shared constants for the Booth radix-2 datapath: default width, recoding-pair encodings, counter sizing.
package booth_pkg;
  localparam int N_DEF = 3;

  // q = {Q[0], Q_1}
  localparam logic [1:0] Q_NOP0 = 2'b00;
  localparam logic [1:0] Q_ADD  = 2'b01;
  localparam logic [1:0] Q_SUB  = 2'b10;
  localparam logic [1:0] Q_NOP1 = 2'b11;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(N_DEF);
endpackage

// File: rtl/booth_addsub.sv
// (N+1)-bit two's-complement adder/subtractor for the Booth accumulator.
// Purely combinational, zero latency, no flow control.
module booth_addsub #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] m,
  input  logic         resta,
  output logic [W-1:0] sum
);
  assign sum = resta ? (a - m) : (a + m);
endmodule

// File: rtl/booth_datapath.sv
// Booth radix-2 signed multiplier datapath driven by controller strobes; producto/valido register 1 cycle after fin with cnt==N.
// No backpressure: strobes act on the edge they are seen. Protocol checking is built only with BOOTH_DP_ERRCHK_EN.
module booth_datapath
  import booth_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cargaQ,
  input  logic           cargaM,
  input  logic           cargaA,
  input  logic           resta,
  input  logic           desp,
  input  logic           fin,
  input  logic [N-1:0]   mcand,
  input  logic [N-1:0]   mplier,
  output logic [1:0]     q,
  output logic [2*N-1:0] producto,
  output logic           valido,
  output logic           err_proto
);
  localparam int CW = cnt_width(N);

  logic [N:0]    a_r;
  logic [N:0]    m_r;
  logic [N-1:0]  q_r;
  logic          q1_r;
  logic [CW-1:0] cnt_r;
  logic [N:0]    sum;
  logic          cnt_done;

  assign cnt_done = (cnt_r == CW'(N));
  assign q        = {q_r[0], q1_r};

  booth_addsub #(.W(N + 1)) u_addsub (
    .a     (a_r),
    .m     (m_r),
    .resta (resta),
    .sum   (sum)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_r      <= '0;
      m_r      <= '0;
      q_r      <= '0;
      q1_r     <= 1'b0;
      cnt_r    <= '0;
      producto <= '0;
      valido   <= 1'b0;
    end else begin
      if (cargaM)
        m_r <= {mcand[N-1], mcand};

      if (cargaQ) begin
        q_r    <= mplier;
        a_r    <= '0;
        q1_r   <= 1'b0;
        cnt_r  <= '0;
        valido <= 1'b0;
      end else begin
        // Simultaneous cargaA/desp is a protocol error; neither is applied.
        if (cargaA && !desp && !cnt_done)
          a_r <= sum;
        else if (desp && !cargaA && !cnt_done) begin
          {a_r, q_r, q1_r} <= {a_r[N], a_r, q_r};
          cnt_r            <= cnt_r + 1'b1;
        end

        if (fin && cnt_done && !valido) begin
          producto <= {a_r[N-1:0], q_r};
          valido   <= 1'b1;
        end
      end
    end
  end

`ifdef BOOTH_DP_ERRCHK_EN
  logic err_ev;

  always_comb begin
    err_ev = 1'b0;
    if (!cargaQ)
      err_ev = (cargaA && desp) || ((cargaA || desp) && cnt_done) || (fin && !cnt_done);
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      err_proto <= 1'b0;
    else if (cargaQ)
      err_proto <= 1'b0;
    else if (err_ev)
      err_proto <= 1'b1;
  end
`else
  assign err_proto = 1'b0;
`endif
endmodule
